// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and data access.
// Data access wins in IDLE; per-requester done flags hold completion until the pipeline advances.
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_n;
    logic             if_done;
    logic             mem_done;
    logic [CNT_W-1:0] cnt;
    logic             we_r;
    logic [3:0]       sel_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic             start_if;
    logic             start_mem;
    logic             acc_ack;
    logic             acc_tmo;

    assign stallreq_if_o  = rom_ce_i & ~if_done;
    assign stallreq_mem_o = ram_ce_i & ~mem_done;

    // Bus fields come only from the latched copy, so requester changes mid-access are ignored.
    assign bus_req_o   = (state != IDLE);
    assign bus_we_o    = we_r;
    assign bus_sel_o   = sel_r;
    assign bus_addr_o  = addr_r;
    assign bus_wdata_o = wdata_r;
    assign dbg_state   = state;

    always_comb begin
        state_n   = state;
        start_if  = 1'b0;
        start_mem = 1'b0;
        acc_ack   = 1'b0;
        acc_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (ram_ce_i && !mem_done) begin
                    state_n   = MEM_ACC;
                    start_mem = 1'b1;
                end else if (rom_ce_i && !if_done) begin
                    state_n  = IF_ACC;
                    start_if = 1'b1;
                end
            end
            IF_ACC, MEM_ACC: begin
                // An ack coinciding with the last timeout cycle counts as a normal completion.
                if (bus_ack_i) begin
                    acc_ack = 1'b1;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    acc_tmo = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            we_r       <= 1'b0;
            sel_r      <= 4'h0;
            addr_r     <= 32'h0;
            wdata_r    <= 32'h0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            rom_data_o <= 32'h0;
            ram_data_o <= 32'h0;
            bus_err_o  <= 1'b0;
        end else begin
            bus_err_o <= acc_tmo;

            if (start_mem) begin
                we_r    <= ram_we_i;
                sel_r   <= ram_sel_i;
                addr_r  <= ram_addr_i;
                wdata_r <= ram_data_i;
                cnt     <= '0;
            end else if (start_if) begin
                we_r    <= 1'b0;
                sel_r   <= 4'hF;
                addr_r  <= rom_addr_i;
                wdata_r <= 32'h0;
                cnt     <= '0;
            end else if (state != IDLE && !bus_ack_i) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Setting a done flag takes priority over the pipeline-advance clear.
            if (state == IF_ACC && (acc_ack || acc_tmo)) begin
                if_done    <= 1'b1;
                rom_data_o <= acc_ack ? bus_rdata_i : 32'h0;
            end else if (!stall_i) begin
                if_done <= 1'b0;
            end

            if (state == MEM_ACC && (acc_ack || acc_tmo)) begin
                mem_done <= 1'b1;
                if (!we_r) begin
                    ram_data_o <= acc_ack ? bus_rdata_i : 32'h0;
                end
            end else if (!stall_i) begin
                mem_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-by-cycle vector table for fetch and simultaneous requests,
// then hand-written sequences for wait states, timeout, done hold and reset mid-access.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        ram_ce_i;
    logic        ram_we_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic        slave_en;
    int          slave_wait;
    logic [31:0] slave_rdata;
    int          busy;

    mem_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
        .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Slave: acks after slave_wait idle bus cycles of the current access.
    assign bus_rdata_i = slave_rdata;
    initial begin
        bus_ack_i = 1'b0;
        busy      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req_o) begin
                bus_ack_i = slave_en && (busy == slave_wait);
                busy++;
            end else begin
                bus_ack_i = 1'b0;
                busy      = 0;
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        rom_ce;
        logic [31:0] rom_addr;
        logic        ram_ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] ram_addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_sif;
        logic        exp_smem;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rom;
        logic [31:0] exp_ram;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_i    = 1'b0;
        rom_ce_i   = 1'b0;
        rom_addr_i = 32'h0;
        ram_ce_i   = 1'b0;
        ram_we_i   = 1'b0;
        ram_sel_i  = 4'h0;
        ram_addr_i = 32'h0;
        ram_data_i = 32'h0;
    endtask

    task automatic drive_fetch(input logic stall, input logic [31:0] addr);
        drive_idle();
        stall_i    = stall;
        rom_ce_i   = 1'b1;
        rom_addr_i = addr;
    endtask

    task automatic drive_read(input logic stall, input logic [31:0] addr);
        drive_idle();
        stall_i    = stall;
        ram_ce_i   = 1'b1;
        ram_sel_i  = 4'hF;
        ram_addr_i = addr;
    endtask

    initial begin
        //             stall rom  rom_addr     ram we sel   ram_addr     wdata         rdata          sif smem req we sel   addr         wdata         rom            ram
        vecs[0] = '{1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h0,         32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h40,  32'h0,        32'h0,         32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'h2402_0005, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'h2402_0005, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'h3C01_1234, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'h2402_0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h3C01_1234, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'h2402_0005, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h44,  32'h0,        32'h3C01_1234, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'h2402_0005, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h2402_0005, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h2402_0005, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h2402_0005, 32'h0};

        // Reset state
        rst         = 1'b1;
        slave_en    = 1'b1;
        slave_wait  = 0;
        slave_rdata = 32'h0;
        drive_idle();
        @(negedge clk);
        check("rst_req",   {31'h0, bus_req_o}, 32'h0);
        check("rst_sel",   {28'h0, bus_sel_o}, 32'h0);
        check("rst_addr",  bus_addr_o, 32'h0);
        check("rst_rom",   rom_data_o, 32'h0);
        check("rst_ram",   ram_data_o, 32'h0);
        check("rst_err",   {31'h0, bus_err_o}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        step();
        rst = 1'b0;

        // Isolated fetch, then simultaneous write + fetch, zero-wait slave
        for (int i = 0; i < 10; i++) begin
            step();
            stall_i     = vecs[i].stall;
            rom_ce_i    = vecs[i].rom_ce;
            rom_addr_i  = vecs[i].rom_addr;
            ram_ce_i    = vecs[i].ram_ce;
            ram_we_i    = vecs[i].we;
            ram_sel_i   = vecs[i].sel;
            ram_addr_i  = vecs[i].ram_addr;
            ram_data_i  = vecs[i].wdata;
            slave_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("v%0d_sif", i),  {31'h0, stallreq_if_o},  {31'h0, vecs[i].exp_sif});
            check($sformatf("v%0d_smem", i), {31'h0, stallreq_mem_o}, {31'h0, vecs[i].exp_smem});
            check($sformatf("v%0d_req", i),  {31'h0, bus_req_o},      {31'h0, vecs[i].exp_req});
            check($sformatf("v%0d_rom", i),  rom_data_o, vecs[i].exp_rom);
            check($sformatf("v%0d_ram", i),  ram_data_o, vecs[i].exp_ram);
            check($sformatf("v%0d_err", i),  {31'h0, bus_err_o}, 32'h0);
            if (vecs[i].exp_req) begin
                check($sformatf("v%0d_we", i),    {31'h0, bus_we_o}, {31'h0, vecs[i].exp_we});
                check($sformatf("v%0d_sel", i),   {28'h0, bus_sel_o}, {28'h0, vecs[i].exp_sel});
                check($sformatf("v%0d_addr", i),  bus_addr_o, vecs[i].exp_addr);
                check($sformatf("v%0d_wdata", i), bus_wdata_o, vecs[i].exp_wdata);
            end
        end

        // Wait states: data read, ack after 3 idle bus cycles
        slave_wait  = 3;
        slave_rdata = 32'h0000_00A5;
        for (int c = 0; c < 6; c++) begin
            step();
            drive_read(c < 5, 32'h200);
            @(negedge clk);
            check($sformatf("ws%0d_req", c),  {31'h0, bus_req_o}, {31'h0, (c >= 1 && c <= 4)});
            check($sformatf("ws%0d_smem", c), {31'h0, stallreq_mem_o}, {31'h0, (c <= 4)});
            check($sformatf("ws%0d_ram", c),  ram_data_o, (c == 5) ? 32'h0000_00A5 : 32'h0);
            if (c >= 1 && c <= 4) begin
                check($sformatf("ws%0d_addr", c), bus_addr_o, 32'h200);
                check($sformatf("ws%0d_we", c),   {31'h0, bus_we_o}, 32'h0);
                check($sformatf("ws%0d_sel", c),  {28'h0, bus_sel_o}, 32'hF);
            end
        end
        step();
        drive_idle();
        slave_wait = 0;
        @(negedge clk);

        // Timeout: slave never acks a fetch
        slave_en = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            if (c <= 5) drive_fetch(c < 5, 32'h80);
            else        drive_idle();
            @(negedge clk);
            check($sformatf("to%0d_req", c), {31'h0, bus_req_o}, {31'h0, (c >= 1 && c <= 4)});
            check($sformatf("to%0d_err", c), {31'h0, bus_err_o}, {31'h0, (c == 5)});
            check($sformatf("to%0d_sif", c), {31'h0, stallreq_if_o}, {31'h0, (c <= 4)});
            check($sformatf("to%0d_rom", c), rom_data_o, (c >= 5) ? 32'h0 : 32'h2402_0005);
            if (c >= 5) check($sformatf("to%0d_state", c), {30'h0, dbg_state}, 32'h0);
            if (c >= 1 && c <= 4) check($sformatf("to%0d_addr", c), bus_addr_o, 32'h80);
        end
        slave_en = 1'b1;

        // Done hold under external stall, then next fetch after the pipeline advances
        slave_rdata = 32'h1111_2222;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c <= 4)      drive_fetch(1'b1, 32'hC0);
            else if (c == 5) drive_fetch(1'b0, 32'hC0);
            else if (c <= 7) drive_fetch(1'b1, 32'hC4);
            else if (c == 8) drive_fetch(1'b0, 32'hC4);
            else             drive_idle();
            if (c >= 6) slave_rdata = 32'h3333_4444;
            @(negedge clk);
            check($sformatf("dh%0d_req", c), {31'h0, bus_req_o}, {31'h0, (c == 1 || c == 7)});
            check($sformatf("dh%0d_sif", c), {31'h0, stallreq_if_o},
                  {31'h0, (c == 0 || c == 1 || c == 6 || c == 7)});
            check($sformatf("dh%0d_rom", c), rom_data_o,
                  (c < 2) ? 32'h0 : ((c < 8) ? 32'h1111_2222 : 32'h3333_4444));
            if (c == 1) check("dh1_addr", bus_addr_o, 32'hC0);
            if (c == 7) check("dh7_addr", bus_addr_o, 32'hC4);
        end

        // Reset asserted during MEM_ACC
        slave_en = 1'b0;
        step();
        drive_read(1'b1, 32'h300);
        @(negedge clk);
        check("rm0_req", {31'h0, bus_req_o}, 32'h0);
        step();
        @(negedge clk);
        check("rm1_req",   {31'h0, bus_req_o}, 32'h1);
        check("rm1_state", {30'h0, dbg_state}, 32'h2);
        #1;
        rst = 1'b1;
        #1;
        check("rm_async_req",   {31'h0, bus_req_o}, 32'h0);
        check("rm_async_state", {30'h0, dbg_state}, 32'h0);
        check("rm_async_addr",  bus_addr_o, 32'h0);
        check("rm_async_sel",   {28'h0, bus_sel_o}, 32'h0);
        check("rm_async_rom",   rom_data_o, 32'h0);
        check("rm_async_ram",   ram_data_o, 32'h0);
        check("rm_async_smem",  {31'h0, stallreq_mem_o}, 32'h1);
        slave_en    = 1'b1;
        slave_rdata = 32'h5555_AAAA;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rm2_state", {30'h0, dbg_state}, 32'h0);
        check("rm2_req",   {31'h0, bus_req_o}, 32'h0);
        step();
        @(negedge clk);
        check("rm3_req",  {31'h0, bus_req_o}, 32'h1);
        check("rm3_addr", bus_addr_o, 32'h300);
        step();
        drive_read(1'b0, 32'h300);
        @(negedge clk);
        check("rm4_ram",  ram_data_o, 32'h5555_AAAA);
        check("rm4_smem", {31'h0, stallreq_mem_o}, 32'h0);
        check("rm4_req",  {31'h0, bus_req_o}, 32'h0);
        step();
        drive_idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
